// File: rtl/handshake_pkg.sv
// Shared types and LFSR helpers for the handshake_if receiving side.
// Back-pressure modes and the Galois LFSR step live here so the bench and RTL agree on names.
package handshake_pkg;

    typedef enum logic [1:0] {
        RM_ALWAYS = 2'd0,
        RM_LFSR   = 2'd1,
        RM_NEVER  = 2'd2,
        RM_RSVD   = 2'd3
    } ready_mode_e;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Right-shifting Galois form: the bit shifted out selects whether the taps are applied.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] shifted;
        shifted = {1'b0, s[15:1]};
        return s[0] ? (shifted ^ LFSR_TAPS) : shifted;
    endfunction

    // An all-zero state locks the LFSR up, so a zero seed is replaced.
    function automatic logic [15:0] lfsr_seed_fix(input logic [15:0] seed);
        return (seed == 16'h0000) ? 16'h0001 : seed;
    endfunction

endpackage

// File: rtl/handshake_lfsr.sv
// 16-bit Galois LFSR that free-runs every cycle; exposes both the current and the next state
// so callers can register a function of the next state without an extra cycle of lag.
module handshake_lfsr
    import handshake_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state,
    output logic [15:0] state_next
);

    localparam logic [15:0] SEED_EFF = lfsr_seed_fix(SEED);

    always_comb begin
        state_next = lfsr_step(state);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SEED_EFF;
        end else begin
            state <= state_next;
        end
    end

endmodule

// File: rtl/handshake_sink.sv
// Receiving end of handshake_if: registered back-pressure (always / LFSR / never), an FWFT
// buffer drained through a simple read port, and beat/stall statistics.
module handshake_sink
    import handshake_pkg::*;
#(
    parameter int          DATA_BITS = 8,
    parameter int          DEPTH     = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_BITS-1:0]     s_data,
    input  logic [1:0]               ready_mode,
    input  logic                     rd_en,
    output logic [DATA_BITS-1:0]     rd_data,
    output logic                     rd_empty,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [31:0]              beat_cnt,
    output logic [31:0]              stall_cnt,
    output logic                     underflow
);

    localparam int                  PTR_W   = $clog2(DEPTH);
    localparam int                  FILL_W  = PTR_W + 1;
    localparam logic [FILL_W-1:0]   DEPTH_F = FILL_W'(DEPTH);
    localparam logic [FILL_W-1:0]   FILL_1  = FILL_W'(1);
    localparam logic [PTR_W-1:0]    PTR_1   = PTR_W'(1);

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;

    logic [15:0]          lfsr_state;
    logic [15:0]          lfsr_next;

    logic                 push;
    logic                 pop;
    logic                 stall;
    logic [FILL_W-1:0]    fill_nxt;
    logic [FILL_W-1:0]    fill_after_pop;
    logic [PTR_W-1:0]     wr_ptr_nxt;
    logic [PTR_W-1:0]     rd_ptr_nxt;
    logic                 bypass;
    logic [DATA_BITS-1:0] head_nxt;
    logic                 pattern_nxt;
    logic                 lfsr_unused;

    handshake_lfsr #(
        .SEED       (LFSR_SEED)
    ) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .state      (lfsr_state),
        .state_next (lfsr_next)
    );

    // Only bit 0 of the next state drives the pattern; the rest is deliberately left unused.
    assign lfsr_unused = ^{lfsr_state, lfsr_next[15:1]};

    assign rd_empty = (fill == '0);
    assign push     = s_valid && s_ready;
    assign pop      = rd_en && !rd_empty;
    assign stall    = s_valid && !s_ready;

    always_comb begin
        fill_nxt = fill;
        case ({push, pop})
            2'b10:   fill_nxt = fill + FILL_1;
            2'b01:   fill_nxt = fill - FILL_1;
            default: fill_nxt = fill;
        endcase
    end

    always_comb begin
        wr_ptr_nxt = push ? (wr_ptr + PTR_1) : wr_ptr;
        rd_ptr_nxt = pop  ? (rd_ptr + PTR_1) : rd_ptr;
    end

    // When the pop leaves nothing behind, the beat being pushed becomes the head directly.
    always_comb begin
        fill_after_pop = pop ? (fill - FILL_1) : fill;
        bypass         = push && (fill_after_pop == '0);
        head_nxt       = bypass ? s_data : mem[rd_ptr_nxt];
    end

    always_comb begin
        case (ready_mode_e'(ready_mode))
            RM_ALWAYS: pattern_nxt = 1'b1;
            RM_LFSR:   pattern_nxt = lfsr_next[0];
            default:   pattern_nxt = 1'b0;
        endcase
    end

    // Storage carries data only, so it needs no reset; fill guards every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_ready   <= 1'b0;
            fill      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_data   <= '0;
            beat_cnt  <= '0;
            stall_cnt <= '0;
            underflow <= 1'b0;
        end else begin
            s_ready <= pattern_nxt && (fill_nxt < DEPTH_F);
            fill    <= fill_nxt;
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            if (fill_nxt != '0) begin
                rd_data <= head_nxt;
            end
            if (push) begin
                beat_cnt <= beat_cnt + 32'd1;
            end
            if (stall) begin
                stall_cnt <= sat_inc32(stall_cnt);
            end
            if (rd_en && rd_empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_handshake_sink.sv
// Scoreboard bench for handshake_sink: accepted beats are queued as they are driven and
// compared against rd_data as the FIFO is drained; s_ready follows an independent LFSR model.
module tb_handshake_sink;
    import handshake_pkg::*;

    localparam int          DATA_BITS = 8;
    localparam int          DEPTH     = 8;
    localparam logic [15:0] SEED      = 16'hACE1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 s_valid;
    logic                 s_ready;
    logic [DATA_BITS-1:0] s_data;
    logic [1:0]           ready_mode;
    logic                 rd_en;
    logic [DATA_BITS-1:0] rd_data;
    logic                 rd_empty;
    logic [3:0]           fill;
    logic [31:0]          beat_cnt;
    logic [31:0]          stall_cnt;
    logic                 underflow;

    always #5 clk = ~clk;

    handshake_sink #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH),
        .LFSR_SEED (SEED)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .ready_mode (ready_mode),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_empty   (rd_empty),
        .fill       (fill),
        .beat_cnt   (beat_cnt),
        .stall_cnt  (stall_cnt),
        .underflow  (underflow)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  q [$];
    logic [15:0] lfsr_m;
    logic        exp_ready;
    logic        exp_uf;
    int          exp_beat;
    int          exp_stall;
    logic        last_acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
        return (s >> 1) ^ ({16{s[0]}} & 16'hB400);
    endfunction

    function automatic logic ref_pattern(input logic [1:0] m, input logic b);
        case (m)
            2'd0:    return 1'b1;
            2'd1:    return b;
            default: return 1'b0;
        endcase
    endfunction

    // Called at a falling edge with inputs already driven; models the next rising edge.
    task automatic tick();
        logic pop;
        #1;
        chk("rd_empty", 32'(rd_empty), 32'(q.size() == 0));
        if (q.size() != 0) chk("rd_data", 32'(rd_data), 32'(q[0]));
        pop = rd_en && (q.size() != 0);
        if (rd_en && q.size() == 0) exp_uf = 1'b1;
        last_acc = s_valid && exp_ready;
        if (s_valid && !exp_ready) exp_stall++;
        if (pop) void'(q.pop_front());
        if (last_acc) begin
            q.push_back(s_data);
            exp_beat++;
        end
        lfsr_m    = ref_lfsr(lfsr_m);
        exp_ready = ref_pattern(ready_mode, lfsr_m[0]) && (q.size() < DEPTH);
        @(posedge clk);
        @(negedge clk);
        chk("s_ready",   32'(s_ready),   32'(exp_ready));
        chk("fill",      32'(fill),      32'(q.size()));
        chk("beat_cnt",  beat_cnt,       32'(exp_beat));
        chk("stall_cnt", stall_cnt,      32'(exp_stall));
        chk("underflow", 32'(underflow), 32'(exp_uf));
    endtask

    task automatic reset_model();
        q.delete();
        lfsr_m    = SEED;
        exp_ready = 1'b0;
        exp_uf    = 1'b0;
        exp_beat  = 0;
        exp_stall = 0;
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        s_valid = 1'b0;
        rd_en   = 1'b0;
        s_data  = '0;
        reset_model();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic send(input logic [7:0] d, input int budget);
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (last_acc) break;
        end
        chk("send_accepted", 32'(last_acc), 32'd1);
    endtask

    task automatic drain(input int budget);
        s_valid = 1'b0;
        rd_en   = 1'b1;
        for (int i = 0; i < budget && q.size() != 0; i++) tick();
        rd_en = 1'b0;
        chk("drain_empty", 32'(rd_empty), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] lfsr_beats [5];
        lfsr_beats = '{8'hD4, 8'hAB, 8'hCD, 8'hEF, 8'h12};

        // Test 1: back-to-back accepts with the reader always draining.
        ready_mode = RM_ALWAYS;
        do_reset();
        chk("t1_rst_ready", 32'(s_ready), 32'd1);
        rd_en = 1'b1;
        send(8'hA1, 1);
        send(8'hB2, 1);
        send(8'hC3, 1);
        s_valid = 1'b0;
        tick();
        chk("t1_beats", beat_cnt, 32'd3);
        chk("t1_stall", stall_cnt, 32'd0);
        chk("t1_empty", 32'(rd_empty), 32'd1);

        // Test 2: fill to DEPTH, observe back-pressure, then pop once to admit 8'h08.
        ready_mode = RM_ALWAYS;
        do_reset();
        rd_en = 1'b0;
        for (int i = 0; i < 8; i++) send(8'(i), 1);
        chk("t2_fill8", 32'(fill), 32'd8);
        chk("t2_full_ready", 32'(s_ready), 32'd0);
        s_valid = 1'b1;
        s_data  = 8'h08;
        repeat (3) tick();
        chk("t2_stall3", stall_cnt, 32'd3);
        chk("t2_head00", 32'(rd_data), 32'h00);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("t2_ready_back", 32'(s_ready), 32'd1);
        tick();
        chk("t2_acc08", 32'(last_acc), 32'd1);
        rd_en = 1'b1;
        send(8'h09, 4);
        drain(16);
        chk("t2_beats", beat_cnt, 32'd10);
        chk("t2_stall", stall_cnt, 32'd5);

        // Test 3: LFSR back-pressure; order and s_ready trace checked every cycle.
        ready_mode = RM_LFSR;
        do_reset();
        rd_en = 1'b1;
        for (int i = 0; i < 5; i++) send(lfsr_beats[i], 64);
        drain(8);
        chk("t3_beats", beat_cnt, 32'd5);

        // Test 4: never ready, then switch to always.
        ready_mode = RM_NEVER;
        do_reset();
        s_valid = 1'b1;
        s_data  = 8'h44;
        repeat (20) tick();
        chk("t4_stall", stall_cnt, 32'd20);
        chk("t4_never_ready", 32'(s_ready), 32'd0);
        ready_mode = RM_ALWAYS;
        s_valid    = 1'b0;
        tick();
        chk("t4_ready_after_switch", 32'(s_ready), 32'd1);
        ready_mode = RM_RSVD;
        tick();
        chk("t4_rsvd_ready", 32'(s_ready), 32'd0);

        // Test 5: underflow is sticky and does not disturb later traffic.
        ready_mode = RM_ALWAYS;
        do_reset();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("t5_underflow", 32'(underflow), 32'd1);
        chk("t5_fill0", 32'(fill), 32'd0);
        send(8'h5A, 4);
        s_valid = 1'b0;
        tick();
        chk("t5_rd5a", 32'(rd_data), 32'h5A);
        drain(4);
        chk("t5_uf_sticky", 32'(underflow), 32'd1);

        // Test 6: asynchronous reset with four beats buffered.
        ready_mode = RM_ALWAYS;
        do_reset();
        rd_en = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h30 + 8'(i), 4);
        chk("t6_fill4", 32'(fill), 32'd4);
        s_valid = 1'b1;
        s_data  = 8'h34;
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_ready",  32'(s_ready),   32'd0);
        chk("t6_rst_fill",   32'(fill),      32'd0);
        chk("t6_rst_empty",  32'(rd_empty),  32'd1);
        chk("t6_rst_rddata", 32'(rd_data),   32'd0);
        chk("t6_rst_beats",  beat_cnt,       32'd0);
        chk("t6_rst_stall",  stall_cnt,      32'd0);
        chk("t6_rst_uf",     32'(underflow), 32'd0);
        s_valid = 1'b0;
        @(negedge clk);
        do_reset();
        send(8'h77, 4);
        s_valid = 1'b0;
        tick();
        chk("t6_first_beat", 32'(rd_data), 32'h77);
        drain(4);
        chk("t6_beats", beat_cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
